// File: rtl/wb_dma_pkg.sv
// Shared register map, CTRL bit positions and FSM encodings for the wb_dma copy engine.
package wb_dma_pkg;

   localparam logic [1:0] REG_SRC  = 2'd0;
   localparam logic [1:0] REG_DST  = 2'd1;
   localparam logic [1:0] REG_LEN  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_BUSY   = 1;
   localparam int CTRL_DONE   = 2;
   localparam int CTRL_IRQ_EN = 3;
   localparam int CTRL_ERR    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/wb_dma.sv
// Single-channel Wishbone DMA: a register slave port programs SRC/DST/LEN and a master
// port copies LEN 32-bit words with classic read-then-write single cycles.
module wb_dma
   import wb_dma_pkg::*;
#(
   parameter int len_width = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_we_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,
   output logic        intr
);

   state_t               state, state_nx;
   logic [31:0]          src, src_nx, dst, dst_nx, data_reg, data_nx;
   logic [len_width-1:0] len, len_nx;
   logic                 done, done_nx, err, err_nx, irq_en, irq_en_nx, busy, busy_nx;
   logic                 ack_nx;
   logic [31:0]          rdat_nx;
   logic                 cyc_nx, we_nx;
   logic [31:0]          madr_nx, mdat_nx;
   logic [3:0]           sel_nx;
   logic                 slv_req, slv_wr, start;
   logic [1:0]           reg_sel;
   logic [31:0]          ctrl_rd;
   logic                 unused_ok;

   assign reg_sel   = wbs_adr_i[3:2];
   assign slv_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign slv_wr    = slv_req & wbs_we_i;
   assign start     = slv_wr && (reg_sel == REG_CTRL) && wbs_dat_i[CTRL_START] && !busy;
   assign intr      = done & irq_en;
   assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

   always_comb begin
      ctrl_rd              = '0;
      ctrl_rd[CTRL_BUSY]   = busy;
      ctrl_rd[CTRL_DONE]   = done;
      ctrl_rd[CTRL_IRQ_EN] = irq_en;
      ctrl_rd[CTRL_ERR]    = err;
   end

   // Register state plus every registered output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         src       <= '0;
         dst       <= '0;
         len       <= '0;
         data_reg  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         irq_en    <= 1'b0;
         busy      <= 1'b0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else begin
         state     <= state_nx;
         src       <= src_nx;
         dst       <= dst_nx;
         len       <= len_nx;
         data_reg  <= data_nx;
         done      <= done_nx;
         err       <= err_nx;
         irq_en    <= irq_en_nx;
         busy      <= busy_nx;
         wbs_ack_o <= ack_nx;
         wbs_dat_o <= rdat_nx;
         wbm_cyc_o <= cyc_nx;
         wbm_stb_o <= cyc_nx;
         wbm_we_o  <= we_nx;
         wbm_sel_o <= sel_nx;
         wbm_adr_o <= madr_nx;
         wbm_dat_o <= mdat_nx;
      end
   end

   // Slave accesses are applied first so that engine events later in this block take
   // priority (a DONE raised by the last beat beats a simultaneous DONE clear).
   always_comb begin
      state_nx  = state;
      src_nx    = src;
      dst_nx    = dst;
      len_nx    = len;
      data_nx   = data_reg;
      done_nx   = done;
      err_nx    = err;
      irq_en_nx = irq_en;
      busy_nx   = busy;
      ack_nx    = slv_req;
      rdat_nx   = wbs_dat_o;
      cyc_nx    = wbm_cyc_o;
      we_nx     = wbm_we_o;
      sel_nx    = wbm_sel_o;
      madr_nx   = wbm_adr_o;
      mdat_nx   = wbm_dat_o;

      if (slv_req && !wbs_we_i) begin
         unique case (reg_sel)
            REG_SRC:  rdat_nx = src;
            REG_DST:  rdat_nx = dst;
            REG_LEN:  rdat_nx = 32'(len);
            REG_CTRL: rdat_nx = ctrl_rd;
         endcase
      end

      if (slv_wr) begin
         unique case (reg_sel)
            REG_SRC:  if (!busy) src_nx = {wbs_dat_i[31:2], 2'b00};
            REG_DST:  if (!busy) dst_nx = {wbs_dat_i[31:2], 2'b00};
            REG_LEN:  if (!busy) len_nx = wbs_dat_i[len_width-1:0];
            REG_CTRL: begin
               irq_en_nx = wbs_dat_i[CTRL_IRQ_EN];
               if (wbs_dat_i[CTRL_DONE]) done_nx = 1'b0;
               if (wbs_dat_i[CTRL_ERR])  err_nx  = 1'b0;
            end
         endcase
      end

      unique case (state)
         ST_IDLE: begin
            cyc_nx = 1'b0;
            if (start) begin
               err_nx = 1'b0;
               if (len != '0) begin
                  state_nx = ST_READ;
                  busy_nx  = 1'b1;
                  done_nx  = 1'b0;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         ST_READ, ST_WRITE: begin
            // A beat is launched only from a cycle with cyc low, which gives the one-cycle
            // gap between beats and after a retry.
            if (!wbm_cyc_o) begin
               cyc_nx = 1'b1;
               sel_nx = 4'hF;
               we_nx  = (state == ST_WRITE);
               if (state == ST_WRITE) begin
                  madr_nx = dst;
                  mdat_nx = data_reg;
               end else begin
                  madr_nx = src;
               end
            end else if (wbm_err_i) begin
               cyc_nx   = 1'b0;
               err_nx   = 1'b1;
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               state_nx = ST_IDLE;
            end else if (wbm_rty_i) begin
               cyc_nx = 1'b0;
            end else if (wbm_ack_i) begin
               cyc_nx = 1'b0;
               if (state == ST_READ) begin
                  data_nx  = wbm_dat_i;
                  state_nx = ST_WRITE;
               end else begin
                  src_nx = src + 32'd4;
                  dst_nx = dst + 32'd4;
                  len_nx = len - len_width'(1);
                  if (len == len_width'(1)) begin
                     done_nx  = 1'b1;
                     busy_nx  = 1'b0;
                     state_nx = ST_IDLE;
                  end else begin
                     state_nx = ST_READ;
                  end
               end
            end
         end
         default: begin
            cyc_nx   = 1'b0;
            state_nx = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/wb_dma.md
WB_DMA -- requirements
Module: wb_dma

Interface
REQ-001 SHALL have parameter len_width, default 16, meaning width of the transfer-length register in 32-bit words.
REQ-002 SHALL have port clk  input  1  system clock; all logic rises on posedge clk.
REQ-003 SHALL have port reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have slave ports wbs_adr_i in 32, wbs_dat_i in 32, wbs_dat_o out 32, wbs_sel_i in 4, wbs_we_i in 1, wbs_stb_i in 1, wbs_cyc_i in 1, wbs_ack_o out 1: the control port, attached as a conbus slave.
REQ-005 SHALL have master ports wbm_adr_o out 32, wbm_dat_o out 32, wbm_dat_i in 32, wbm_sel_o out 4, wbm_we_o out 1, wbm_stb_o out 1, wbm_cyc_o out 1, wbm_ack_i in 1, wbm_err_i in 1, wbm_rty_i in 1: the copy engine, attached as a conbus master (slot m2).
REQ-006 SHALL have port intr  output  1  level interrupt, active-high.

Function
REQ-007 SHALL decode the register map on wbs_adr_i[3:2]:
- 0: SRC
- 1: DST
- 2: LEN
- 3: CTRL (bit0 START write-only; bit1 BUSY read-only; bit2 DONE sticky, write 1 to clear; bit3 IRQ_EN; bit4 ERR sticky, write 1 to clear).
REQ-008 SHALL assert wbs_ack_o for exactly one cycle, one cycle after wbs_cyc_i & wbs_stb_i & !wbs_ack_o; writes and reads take effect on that ack cycle.
REQ-009 SHALL force bits [1:0] of SRC and DST to 0 on write; SHALL zero-extend LEN on read-back; SHALL ignore wbs_sel_i (word access only).
REQ-010 SHALL ignore writes to SRC, DST, LEN and START while BUSY=1; DONE/ERR clear and IRQ_EN writes SHALL always apply.
REQ-011 SHALL implement FSM states IDLE, READ, WRITE.
- IDLE -> READ on START with LEN != 0; sets BUSY and clears DONE and ERR.
- START with LEN == 0 SHALL set DONE in the same cycle, with no bus cycle.
REQ-012 In READ, SHALL drive cyc=stb=1, we=0, sel=4'hF, adr=SRC; on wbm_ack_i SHALL latch wbm_dat_i into a data register and go to WRITE.
REQ-013 In WRITE, SHALL drive cyc=stb=1, we=1, sel=4'hF, adr=DST, dat=the latched word; on wbm_ack_i SHALL:
- SRC += 4, DST += 4 (modulo 2^32, wrap without error);
- LEN -= 1;
- go to IDLE with DONE=1 if the new LEN == 0, else to READ.
REQ-014 SHALL deassert wbm_cyc_o and wbm_stb_o for exactly one cycle between consecutive beats (classic single cycles, no bursts, no lock).
REQ-015 On wbm_rty_i SHALL drop cyc/stb for one cycle and reissue the same beat with unchanged address and data.
REQ-016 On wbm_err_i SHALL drop cyc/stb, set ERR and DONE, go to IDLE, and leave SRC/DST/LEN holding the failed beat's values.
REQ-017 SHALL drive intr = DONE & IRQ_EN combinationally from registers.
REQ-018 Master outputs SHALL be registered; cyc and stb SHALL be 0 in IDLE.
REQ-019 A master ack arriving while cyc=0 SHALL be ignored.

Reset
REQ-020 On reset_n=0, SHALL asynchronously clear all of the following to 0 and put the FSM in IDLE: SRC, DST, LEN, DONE, ERR, IRQ_EN, BUSY, the data register, wbs_ack_o, wbs_dat_o, and all master outputs.
REQ-021 Reset asserted mid-transfer SHALL abandon the beat immediately; no partial state SHALL survive.

Structure
REQ-022 A shared package SHALL hold the register offsets, CTRL bit positions and FSM state encodings.
REQ-023 The block SHALL be a single module with no sub-modules.
REQ-024 It SHALL total 150-300 lines of RTL.

Verification
REQ-025 Write SRC=0x40000000, DST=0x40000100, LEN=4, CTRL=0x9 -> exactly 8 master beats alternating read/write; memory copy is correct; DONE=1, intr=1, LEN reads 0, SRC reads 0x40000010.
REQ-026 START with LEN=0 -> no wbm_cyc_o assertion; DONE=1 on the next read.
REQ-027 Slave model asserts wbm_err_i on the 2nd read -> ERR=1, DONE=1, BUSY=0, LEN reads 3, cyc low within 1 cycle.
REQ-028 Slave asserts wbm_rty_i once on a write -> that write is reissued at the same address; the final copy is intact.
REQ-029 Write SRC=0x1234 while BUSY -> readback is unchanged; SRC=0xFFFFFFFC, LEN=2 -> the second read address is 0x00000000.
REQ-030 Assert reset_n low mid-WRITE -> cyc/stb/ack drop asynchronously; all registers read 0 after release.
